uart_imem_programmer: RTL and testbench

- UART receive-and-load block upstream of the fetch stage; supplies `imem_din` and `memcon_prog_ena` to the instruction-memory port.
- Receives 8N1 serial bytes on `rx` while `prog` is high.
- Assembles each four bytes into a little-endian 32-bit word and issues one write strobe per word at an auto-incrementing byte address.
- Fetch/pipeline stay stalled via `dbg` while `prog` is high; this block owns the imem write path during that window.

---
 rtl/uart_imem_programmer.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_imem_programmer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_programmer.sv
// UART 8N1 receiver that packs little-endian words into instruction memory.
// Optional checksum outputs are enabled by defining UART_IMEM_PROG_CHECKSUM_EN.
module uart_imem_programmer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 12,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              prog,
    input  logic              rx,
    output logic [31:0]       imem_din,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic              memcon_prog_ena,
    output logic [ADDR_W-2:0] word_count,
    output logic              frame_err
`ifdef UART_IMEM_PROG_CHECKSUM_EN
    ,
    output logic [7:0]        checksum,
    output logic [0:0]        checksum_ok
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prog_q, prog_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [1:0]             idx_q, idx_d;
    logic [23:0]            hold_q, hold_d;
    logic [31:0]            din_q, din_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-2:0]      wcnt_q, wcnt_d;
    logic                   ferr_q, ferr_d;
`ifdef UART_IMEM_PROG_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    logic rx_s;
    logic prog_rise;
    logic cnt_full;
    logic cnt_half;
    logic byte_ok;
    logic byte_bad;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign prog_rise = prog & ~prog_q;
    assign cnt_full  = (cnt_q == FULL);
    assign cnt_half  = (cnt_q == HALF);
    assign byte_ok   = prog & (state_q == STOP) & cnt_full & rx_s;
    assign byte_bad  = prog & (state_q == STOP) & cnt_full & ~rx_s;

    assign imem_din        = din_q;
    assign imem_addr       = addr_q;
    assign imem_we         = we_q;
    assign memcon_prog_ena = prog_q;
    assign word_count      = wcnt_q;
    assign frame_err       = ferr_q;
`ifdef UART_IMEM_PROG_CHECKSUM_EN
    assign checksum        = sum_q;
    assign checksum_ok     = (sum_q == 8'h00) && (wcnt_q != '0);
`endif

    // Receiver state register
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receiver next state; leaving prog or a new session forces IDLE
    always_comb begin
        state_d = state_q;
        if (!prog || prog_rise) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_half) begin
                        state_d = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_full && bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (cnt_full) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: baud timing, byte shifting, word packing and address stepping
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
        prog_d  = prog;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        din_d   = din_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        ferr_d  = ferr_q;
`ifdef UART_IMEM_PROG_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            START: begin
                cnt_d = cnt_half ? 16'd0 : cnt_q + 16'd1;
                bit_d = '0;
            end
            DATA: begin
                cnt_d = cnt_full ? 16'd0 : cnt_q + 16'd1;
                if (cnt_full) begin
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + 3'd1;
                end
            end
            STOP: begin
                cnt_d = cnt_full ? 16'd0 : cnt_q + 16'd1;
            end
            default: cnt_d = '0;
        endcase

        if (byte_ok) begin
            idx_d = idx_q + 2'd1;
            unique case (idx_q)
                2'd0: hold_d[7:0]   = shift_q;
                2'd1: hold_d[15:8]  = shift_q;
                2'd2: hold_d[23:16] = shift_q;
                default: begin
                    din_d = {shift_q, hold_q};
                    we_d  = 1'b1;
                end
            endcase
`ifdef UART_IMEM_PROG_CHECKSUM_EN
            sum_d = sum_q + shift_q;
`endif
        end

        if (byte_bad) begin
            ferr_d = 1'b1;
            idx_d  = '0;
        end

        // A strobe already launched finishes even if prog drops now
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(4);
            wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
        end

        if (!prog) begin
            idx_d = '0;
        end

        if (prog_rise) begin
            addr_d = '0;
            wcnt_d = '0;
            idx_d  = '0;
            ferr_d = 1'b0;
`ifdef UART_IMEM_PROG_CHECKSUM_EN
            sum_d  = '0;
`endif
        end
    end

    // Datapath registers; the rx synchronizer resets to the idle level
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            sync_q  <= '1;
            prog_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            ferr_q  <= 1'b0;
`ifdef UART_IMEM_PROG_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            sync_q  <= sync_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            din_q   <= din_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            ferr_q  <= ferr_d;
`ifdef UART_IMEM_PROG_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_imem_programmer.sv
// Bench for uart_imem_programmer: serial byte driver, word model, strobe scoreboard.
// Checksum checks follow UART_IMEM_PROG_CHECKSUM_EN.
module tb_uart_imem_programmer;

    localparam int CPB = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          Rst = 1'b0;
    logic          prog = 1'b0;
    logic          rx = 1'b1;
    logic [31:0]   imem_din;
    logic [AW-1:0] imem_addr;
    logic          imem_we;
    logic          memcon_prog_ena;
    logic [AW-2:0] word_count;
    logic          frame_err;
`ifdef UART_IMEM_PROG_CHECKSUM_EN
    logic [7:0]    checksum;
    logic [0:0]    checksum_ok;
`endif

    uart_imem_programmer #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(AW),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .Rst(Rst),
        .prog(prog),
        .rx(rx),
        .imem_din(imem_din),
        .imem_addr(imem_addr),
        .imem_we(imem_we),
        .memcon_prog_ena(memcon_prog_ena),
        .word_count(word_count),
        .frame_err(frame_err)
`ifdef UART_IMEM_PROG_CHECKSUM_EN
        ,
        .checksum(checksum),
        .checksum_ok(checksum_ok)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_we = 0;
    int m_push = 0;

    logic [35:0]   sb[$];
    int            m_idx = 0;
    logic [31:0]   m_word = '0;
    logic [AW-1:0] m_addr = '0;
    int            m_cnt = 0;
    logic          m_err = 1'b0;
    logic [7:0]    m_sum = '0;

    // Single comparison point for every check
    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe monitor: each write must match the oldest expected word
    always @(negedge clk) begin
        if (Rst && imem_we) begin
            logic [35:0] e;
            n_we++;
            if (sb.size() == 0) begin
                chk("we_extra", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("we_addr", 32'(imem_addr), 32'(e[35:32]));
                chk("we_din", imem_din, e[31:0]);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame; the model is updated before the line moves
    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (prog) begin
            if (stop) begin
                m_word[8*m_idx +: 8] = b;
                m_sum = m_sum + b;
                m_idx++;
                if (m_idx == 4) begin
                    sb.push_back({m_addr, m_word});
                    m_push++;
                    m_addr = m_addr + AW'(4);
                    if (m_cnt < (1 << (AW - 1)) - 1) m_cnt++;
                    m_idx = 0;
                end
            end else begin
                m_err = 1'b1;
                m_idx = 0;
            end
        end
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop;
        wait_cyc(CPB);
        rx = 1'b1;
        wait_cyc(24);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    task automatic new_session();
        prog = 1'b0;
        m_idx = 0;
        wait_cyc(3);
        prog = 1'b1;
        m_addr = '0;
        m_cnt = 0;
        m_err = 1'b0;
        m_sum = '0;
        wait_cyc(3);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(m_addr));
        chk({tag, "_cnt"}, 32'(word_count), 32'(m_cnt));
        chk({tag, "_err"}, 32'(frame_err), 32'(m_err));
    endtask

    initial begin
        int we0;
        wait_cyc(4);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_cnt", 32'(word_count), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_din", imem_din, 32'd0);
        chk("rst_ena", 32'(memcon_prog_ena), 32'd0);
        Rst = 1'b1;
        wait_cyc(3);

        // Single word
        prog = 1'b1;
        wait_cyc(2);
        chk("ena_on", 32'(memcon_prog_ena), 32'd1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk_state("w1");

        // Two words
        new_session();
        send_word(32'h0010_0093);
        send_word(32'h0020_8113);
        chk_state("w2");

        // Framing error then a clean word
        new_session();
        send_byte(8'hAA, 1'b0);
        send_word(32'hDEAD_BEEF);
        chk_state("ferr");

        // Partial word then prog drop: values hold for readback
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        prog = 1'b0;
        m_idx = 0;
        wait_cyc(10);
        chk_state("drop");
        chk("drop_ena", 32'(memcon_prog_ena), 32'd0);
        prog = 1'b1;
        m_addr = '0;
        m_cnt = 0;
        m_err = 1'b0;
        m_sum = '0;
        wait_cyc(3);
        chk_state("rise");
        send_word(32'hCAFE_0001);
        chk_state("after_rise");

        // Short low glitch in IDLE
        we0 = n_we;
        rx = 1'b0;
        wait_cyc(1);
        rx = 1'b1;
        wait_cyc(40);
        chk("glitch_we", 32'(n_we), 32'(we0));
        chk_state("glitch");
        send_word(32'h1234_5678);

        // Address wrap and word count saturation
        new_session();
        for (int k = 0; k < 5; k++) begin
            send_word(32'hA000_0000 + 32'(k));
        end
        chk_state("wrap");
        for (int k = 5; k < 8; k++) begin
            send_word(32'hA000_0000 + 32'(k));
        end
        chk_state("sat");

`ifdef UART_IMEM_PROG_CHECKSUM_EN
        new_session();
        send_word(32'h0403_0201);
        chk("csum_mid", 32'(checksum), 32'(m_sum));
        chk("csum_ok_mid", 32'(checksum_ok), 32'd0);
        send_byte(8'hF6, 1'b1);
        chk("csum_end", 32'(checksum), 32'(m_sum));
        chk("csum_ok_end", 32'(checksum_ok), 32'd1);
`endif

        wait_cyc(10);
        chk("sb_left", 32'(sb.size()), 32'd0);
        chk("we_total", 32'(n_we), 32'(m_push));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
